regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Arbiter that shares the single register-file write port (scalar and vector banks) between the pipeline write-back stage and an external write requester (interpolation loader / host preload). Pipeline write-back has priority and cannot be back-pressured. The external requester uses a valid/ready handshake and is protected from starvation by a counter-driven pipeline stall request. The block sits between the write-back stage and the instruction-decode register files, driving their write-enable, destination and data inputs.

## Interface

Parameters:
- DATA_W, 256, write data width (vector width; scalar bank uses bits [31:0])
- ADDR_W, 5, register index width
- STARVE_MAX, 4, consecutive denied external cycles before stall_req asserts (legal 1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- wb_valid  in  1  pipeline write-back wants the port this cycle
- wb_vec  in  1  1 = vector bank, 0 = scalar bank (pipeline)
- wb_rd  in  ADDR_W  pipeline destination register
- wb_data  in  DATA_W  pipeline write data
- ext_valid  in  1  external write request pending
- ext_ready  out  1  external request accepted this cycle
- ext_vec  in  1  bank select (external)
- ext_rd  in  ADDR_W  external destination register
- ext_data  in  DATA_W  external write data
- stall_req  out  1  request to freeze the pipeline so the external side gets the port
- wr_scalar  out  1  scalar bank write enable
- wr_vector  out  1  vector bank write enable
- wr_rd  out  ADDR_W  destination register to the register files
- wr_data  out  DATA_W  data to the register files
- wr_src  out  1  0 = pipeline, 1 = external (debug/trace)

## Operation

- Grant rule, evaluated each cycle: wb_valid=1 → pipeline wins; else ext_valid=1 → external wins; else idle.
- ext_ready = ext_valid & ~wb_valid (combinational). Transfer occurs on ext_valid & ext_ready at the rising edge; the external side holds ext_vec/ext_rd/ext_data stable while ext_valid=1 and ext_ready=0.
- Winner's request is registered onto wr_*. wr_scalar = granted & ~vec; wr_vector = granted & vec; never both high. Idle cycle: both enables 0; wr_rd, wr_data, wr_src hold their previous values.
- Starvation counter starve_cnt (4 bits): increments when ext_valid & wb_valid; clears on any external transfer or when ext_valid=0; saturates at STARVE_MAX.
- FSM states:
  - PIPE: stall_req=0. Go to HOLD when starve_cnt reaches STARVE_MAX.
  - HOLD: stall_req=1. The pipeline deasserts wb_valid no later than the cycle after it sees stall_req. A wb_valid still present in HOLD still wins; the arbiter never drops a pipeline write. Go to PIPE on the external transfer edge, or if ext_valid falls (request withdrawn).
- Same register written by both sides on consecutive cycles: writes are serialized in grant order; the later write wins in the register file. No merging or forwarding.

## Timing

- Reset (rst=0, asynchronous): wr_scalar=0, wr_vector=0, wr_rd=0, wr_data=0, wr_src=0, stall_req=0, starve_cnt=0, state=PIPE. ext_ready follows its combinational equation during reset, but transfers during reset are ignored.
- Reset deassertion mid-operation: any accepted but not yet driven write is lost. The external side must re-present it.
- Latency: a request granted at edge N appears on wr_* during cycle N+1 (one register stage). Register files sample at edge N+1.
- Throughput: one write per cycle. Back-to-back external transfers are allowed when wb_valid=0.
- stall_req rises on the edge where starve_cnt becomes STARVE_MAX, i.e. after STARVE_MAX consecutive denied cycles. It falls on the edge of the external transfer.

## Structure

- Package regfile_wb_pkg holds:
  - the arb_state_t enum (PIPE, HOLD)
  - the wr_req_t struct (vec, rd, data)
  - STARVE_CNT_W = 4
- One sub-module, wb_starve_counter: saturating counter with inc/clr/limit, which outputs the limit-reached flag.
- Top module contains the grant logic, FSM and output register.

## Test plan

- Reset: hold rst=0 with random inputs → all wr_* = 0 and stall_req=0; release → first grant appears one cycle after the request.
- Pipeline only: wb_valid=1, wb_vec=0, wb_rd=3, wb_data=0x…DEADBEEF → next cycle wr_scalar=1, wr_vector=0, wr_rd=3, wr_data[31:0]=DEADBEEF, wr_src=0.
- External only: ext_valid=1, ext_vec=1, ext_rd=7 for 3 beats, wb_valid=0 → ext_ready=1 each cycle; wr_vector=1, wr_src=1 for 3 consecutive cycles.
- Starvation (STARVE_MAX=4): ext_valid=1 and wb_valid=1 continuously → ext_ready=0; stall_req=1 after the 4th denied edge. Then drop wb_valid → external transfer, stall_req=0 next cycle, starve_cnt=0.
- HOLD with in-flight write: stall_req=1 and wb_valid still 1 for one cycle → the pipeline write is committed first, the external write follows on the next cycle, and no write is lost or duplicated.
- Withdrawal and async reset: in HOLD, drop ext_valid → back to PIPE with stall_req=0. Assert rst mid-burst → outputs clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file write-port arbiter.
// The write-request struct is sized at the default port widths.
package regfile_wb_pkg;

   localparam int STARVE_CNT_W = 4;
   localparam int RF_ADDR_W    = 5;
   localparam int RF_DATA_W    = 256;

   typedef enum logic {
      PIPE = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic                 vec;
      logic [RF_ADDR_W-1:0] rd;
      logic [RF_DATA_W-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_starve.sv
// Saturating counter of consecutive cycles the external requester lost the port.
// o_reach flags that the count lands on LIMIT at the coming edge.
module wb_starve_counter
   import regfile_wb_pkg::*;
#(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_reach
);

   localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(LIMIT);

   logic [STARVE_CNT_W-1:0] r_cnt;
   logic [STARVE_CNT_W-1:0] w_cnt_nxt;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_clr)
         w_cnt_nxt = '0;
      else if (i_inc && (r_cnt < LIM))
         w_cnt_nxt = r_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_cnt <= '0;
      else
         r_cnt <= w_cnt_nxt;
   end

   assign o_reach = (w_cnt_nxt == LIM);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline write-back (priority,
// never stalled by this block) and an external valid/ready requester.
//
// state | meaning
// PIPE  | normal arbitration, stall_req low
// HOLD  | external side starved, stall_req high until it transfers or withdraws
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int DATA_W     = RF_DATA_W,
   parameter int ADDR_W     = RF_ADDR_W,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_valid,
   input  logic              wb_vec,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ext_valid,
   output logic              ext_ready,
   input  logic              ext_vec,
   input  logic [ADDR_W-1:0] ext_rd,
   input  logic [DATA_W-1:0] ext_data,
   output logic              stall_req,
   output logic              wr_scalar,
   output logic              wr_vector,
   output logic [ADDR_W-1:0] wr_rd,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_src
);

   arb_state_t r_state, w_state_nxt;
   wr_req_t    w_req, r_req;
   logic       w_grant, w_ext_xfer, w_reach;
   logic       r_wr_scalar, r_wr_vector, r_wr_src;

   assign w_ext_xfer = ext_valid & ~wb_valid;
   assign w_grant    = wb_valid | ext_valid;
   assign ext_ready  = w_ext_xfer;

   always_comb begin
      w_req = wb_valid ? '{vec: wb_vec,  rd: wb_rd,  data: wb_data}
                       : '{vec: ext_vec, rd: ext_rd, data: ext_data};
   end

   wb_starve_counter #(
      .LIMIT (STARVE_MAX)
   ) u_starve (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (ext_valid & wb_valid),
      .i_clr   (w_ext_xfer | ~ext_valid),
      .o_reach (w_reach)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         PIPE:    if (w_reach) w_state_nxt = HOLD;
         HOLD:    if (w_ext_xfer || !ext_valid) w_state_nxt = PIPE;
         default: w_state_nxt = PIPE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= PIPE;
      else
         r_state <= w_state_nxt;
   end

   // Destination/data/source hold through idle cycles; only enables drop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_scalar <= 1'b0;
         r_wr_vector <= 1'b0;
         r_wr_src    <= 1'b0;
         r_req       <= '0;
      end else begin
         r_wr_scalar <= w_grant & ~w_req.vec;
         r_wr_vector <= w_grant &  w_req.vec;
         if (w_grant) begin
            r_req    <= w_req;
            r_wr_src <= ~wb_valid;
         end
      end
   end

   assign stall_req = (r_state == HOLD);
   assign wr_scalar = r_wr_scalar;
   assign wr_vector = r_wr_vector;
   assign wr_rd     = r_req.rd;
   assign wr_data   = r_req.data;
   assign wr_src    = r_wr_src;

endmodule
